// File: rtl/alu_issue.sv
// Command front-end for the ALU: queues commands, issues one at a time onto
// registered ALU inputs, then captures the result for a valid/ready consumer.
module alu_issue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int TAGW  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_op,
    input  logic [WIDTH-1:0]         cmd_a,
    input  logic [WIDTH-1:0]         cmd_b,
    input  logic [TAGW-1:0]          cmd_tag,
    output logic [2:0]               alu_op,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    input  logic [WIDTH-1:0]         alu_result,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [WIDTH-1:0]         res_data,
    output logic [TAGW-1:0]          res_tag,
    output logic                     res_zero,
    output logic                     res_illegal,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [2:0] OP_ILLEGAL = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [TAGW-1:0]  tag;
    } cmd_t;

    cmd_t            fifo_q [DEPTH];
    cmd_t            cmd_in;
    cmd_t            head;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    state_e          state_q, state_d;
    logic            push, pop, capture, fifo_empty;
    logic            res_valid_q, res_valid_d;

    logic [2:0]       alu_op_q;
    logic [WIDTH-1:0] alu_a_q, alu_b_q;
    logic [TAGW-1:0]  tag_q;
    logic [WIDTH-1:0] res_data_q;
    logic [TAGW-1:0]  res_tag_q;
    logic             res_zero_q, res_illegal_q;
    logic             cur_illegal;

    assign cmd_in     = '{op: cmd_op, a: cmd_a, b: cmd_b, tag: cmd_tag};
    assign head       = fifo_q[rd_ptr_q];
    assign fifo_empty = (count_q == '0);

    // Ready depends only on registered occupancy (and reset), never on the handshakes.
    assign cmd_ready  = rst_n & (count_q != CW'(DEPTH));
    assign push       = cmd_valid & cmd_ready & ~flush;

    // NOTE: combinational blocks assign every output a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        res_valid_d = res_valid_q;
        pop         = 1'b0;
        capture     = 1'b0;
        if (flush) begin
            state_d     = IDLE;
            res_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = EXEC;
                    end
                end
                EXEC: begin
                    capture     = 1'b1;
                    res_valid_d = 1'b1;
                    state_d     = DONE;
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid_d = 1'b0;
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            state_d = EXEC;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            res_valid_q <= res_valid_d;
        end
    end

    // NOTE: FIFO storage has no reset; only pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= cmd_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (!push && pop) count_q <= count_q - CW'(1);
        end
    end

    // ALU inputs change only on a pop, so they are stable throughout EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op_q <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            tag_q    <= '0;
        end else if (pop) begin
            alu_op_q <= head.op;
            alu_a_q  <= head.a;
            alu_b_q  <= head.b;
            tag_q    <= head.tag;
        end
    end

    assign cur_illegal = (alu_op_q == OP_ILLEGAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data_q    <= '0;
            res_tag_q     <= '0;
            res_zero_q    <= 1'b0;
            res_illegal_q <= 1'b0;
        end else if (capture) begin
            res_data_q    <= cur_illegal ? '0 : alu_result;
            res_tag_q     <= tag_q;
            res_illegal_q <= cur_illegal;
            res_zero_q    <= cur_illegal | (alu_result == '0);
        end
    end

    assign alu_op      = alu_op_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign res_tag     = res_tag_q;
    assign res_zero    = res_zero_q;
    assign res_illegal = res_illegal_q;
    assign fifo_count  = count_q;
    assign busy        = (state_q != IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_alu_issue.sv
// Directed self-checking bench for alu_issue; a behavioural ALU closes the loop
// and every expected value is a hand-computed constant.
module tb_alu_issue;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2;
    localparam int TAGW  = 4;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a, cmd_b;
    logic [TAGW-1:0]  cmd_tag;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_a, alu_b, alu_result;
    logic             res_valid, res_ready;
    logic [WIDTH-1:0] res_data;
    logic [TAGW-1:0]  res_tag;
    logic             res_zero, res_illegal;
    logic [$clog2(DEPTH):0] fifo_count;
    logic             busy;

    int n_cmp = 0;
    int n_err = 0;

    alu_issue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_tag    (cmd_tag),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_tag    (res_tag),
        .res_zero   (res_zero),
        .res_illegal(res_illegal),
        .fifo_count (fifo_count),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream ALU; the illegal opcode returns a non-zero pattern the DUT must suppress.
    always_comb begin
        alu_result = 32'hDEAD_BEEF;
        case (alu_op)
            3'b000: alu_result = alu_a + alu_b;
            3'b001: alu_result = alu_a - alu_b;
            3'b010: alu_result = $signed(alu_a) >>> alu_b[4:0];
            3'b011: alu_result = alu_a >> alu_b[4:0];
            3'b100: alu_result = alu_a << alu_b[4:0];
            3'b101: alu_result = alu_a & alu_b;
            3'b110: alu_result = alu_a | alu_b;
            default: alu_result = 32'hDEAD_BEEF;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag);
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_tag   = tag;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic get_result(input string name, input logic [31:0] data, input logic [3:0] tag,
                              input logic zero, input logic ill);
        for (int i = 0; i < 8; i++) begin
            if (res_valid) break;
            step();
        end
        check({name, "_valid"}, 64'(res_valid), 64'd1);
        check({name, "_data"}, 64'(res_data), 64'(data));
        check({name, "_tag"}, 64'(res_tag), 64'(tag));
        check({name, "_zero"}, 64'(res_zero), 64'(zero));
        check({name, "_illegal"}, 64'(res_illegal), 64'(ill));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = 3'b000;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_tag   = '0;
        res_ready = 1'b0;

        // Reset held with a command offered
        #12;
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_fifo_count", 64'(fifo_count), 64'd0);
        check("rst_alu_a", 64'(alu_a), 64'd0);
        cmd_valid = 1'b0;
        #10;
        rst_n = 1'b1;
        #1;
        check("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("post_rst_busy", 64'(busy), 64'd0);
        step();

        // ADD with exact latency
        res_ready = 1'b1;
        send(3'b000, 32'd5, 32'd3, 4'd7);
        check("add_k_count", 64'(fifo_count), 64'd1);
        check("add_k_busy", 64'(busy), 64'd1);
        check("add_k_res_valid", 64'(res_valid), 64'd0);
        step();
        check("add_k1_alu_op", 64'(alu_op), 64'd0);
        check("add_k1_alu_a", 64'(alu_a), 64'd5);
        check("add_k1_alu_b", 64'(alu_b), 64'd3);
        check("add_k1_res_valid", 64'(res_valid), 64'd0);
        check("add_k1_count", 64'(fifo_count), 64'd0);
        step();
        check("add_k2_res_valid", 64'(res_valid), 64'd1);
        get_result("add", 32'd8, 4'd7, 1'b0, 1'b0);
        step();
        check("add_done_valid", 64'(res_valid), 64'd0);
        check("add_done_busy", 64'(busy), 64'd0);

        // SUB wrap and SUB to zero
        send(3'b001, 32'd3, 32'd5, 4'd1);
        get_result("sub_wrap", 32'hFFFF_FFFE, 4'd1, 1'b0, 1'b0);
        step();
        send(3'b001, 32'd9, 32'd9, 4'd2);
        get_result("sub_zero", 32'd0, 4'd2, 1'b1, 1'b0);
        step();

        // Backpressure: three accepted, fourth refused
        res_ready = 1'b0;
        cmd_op = 3'b000; cmd_a = 32'd1; cmd_b = 32'd2; cmd_tag = 4'd1; cmd_valid = 1'b1;
        check("bp_ready0", 64'(cmd_ready), 64'd1);
        step();
        cmd_op = 3'b101; cmd_a = 32'h0000_F0F0; cmd_b = 32'h0000_FF00; cmd_tag = 4'd2;
        check("bp_ready1", 64'(cmd_ready), 64'd1);
        step();
        cmd_op = 3'b100; cmd_a = 32'd1; cmd_b = 32'd4; cmd_tag = 4'd3;
        check("bp_ready2", 64'(cmd_ready), 64'd1);
        step();
        cmd_op = 3'b110; cmd_a = 32'd8; cmd_b = 32'd1; cmd_tag = 4'd4;
        check("bp_ready3_blocked", 64'(cmd_ready), 64'd0);
        check("bp_count_full", 64'(fifo_count), 64'd2);
        check("bp_res_valid", 64'(res_valid), 64'd1);
        check("bp_res_tag", 64'(res_tag), 64'd1);
        check("bp_res_data", 64'(res_data), 64'd3);
        step();
        cmd_valid = 1'b0;
        check("bp_hold_count", 64'(fifo_count), 64'd2);
        check("bp_hold_data", 64'(res_data), 64'd3);
        check("bp_hold_valid", 64'(res_valid), 64'd1);
        res_ready = 1'b1;
        step();
        check("bp_pop_valid", 64'(res_valid), 64'd0);
        check("bp_pop_count", 64'(fifo_count), 64'd1);
        check("bp_pop_ready", 64'(cmd_ready), 64'd1);
        step();
        check("bp_r2_valid", 64'(res_valid), 64'd1);
        check("bp_r2_data", 64'(res_data), 64'h0000_F000);
        check("bp_r2_tag", 64'(res_tag), 64'd2);
        step();
        check("bp_gap_valid", 64'(res_valid), 64'd0);
        step();
        check("bp_r3_valid", 64'(res_valid), 64'd1);
        check("bp_r3_data", 64'(res_data), 64'h10);
        check("bp_r3_tag", 64'(res_tag), 64'd3);
        step();
        step();
        check("bp_no_fourth", 64'(res_valid), 64'd0);
        check("bp_idle_busy", 64'(busy), 64'd0);

        // Shifts at the sign boundary
        send(3'b010, 32'h8000_0000, 32'd4, 4'd5);
        get_result("sra", 32'hF800_0000, 4'd5, 1'b0, 1'b0);
        step();

        // Illegal opcode forces zero data
        send(3'b111, 32'd1, 32'd1, 4'd9);
        get_result("illegal", 32'd0, 4'd9, 1'b1, 1'b1);
        step();
        send(3'b011, 32'h8000_0000, 32'd4, 4'd6);
        get_result("srl", 32'h0800_0000, 4'd6, 1'b0, 1'b0);
        step();

        // Flush with queued work and a push on the flush edge
        res_ready = 1'b0;
        send(3'b000, 32'd1, 32'd1, 4'd4);
        send(3'b000, 32'd2, 32'd2, 4'd5);
        check("fl_pre_count", 64'(fifo_count), 64'd1);
        cmd_op = 3'b000; cmd_a = 32'd3; cmd_b = 32'd3; cmd_tag = 4'd6; cmd_valid = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        cmd_valid = 1'b0;
        check("fl_count", 64'(fifo_count), 64'd0);
        check("fl_res_valid", 64'(res_valid), 64'd0);
        check("fl_busy", 64'(busy), 64'd0);
        check("fl_alu_a_held", 64'(alu_a), 64'd1);
        check("fl_res_data_held", 64'(res_data), 64'h0800_0000);
        for (int i = 0; i < 4; i++) step();
        check("fl_no_result", 64'(res_valid), 64'd0);
        check("fl_still_idle", 64'(busy), 64'd0);

        // Asynchronous reset while in EXEC
        res_ready = 1'b1;
        send(3'b000, 32'd10, 32'd20, 4'd6);
        step();
        check("ar_exec_alu_a", 64'(alu_a), 64'd10);
        #3;
        rst_n = 1'b0;
        #1;
        check("ar_alu_a", 64'(alu_a), 64'd0);
        check("ar_res_data", 64'(res_data), 64'd0);
        check("ar_busy", 64'(busy), 64'd0);
        check("ar_cmd_ready", 64'(cmd_ready), 64'd0);
        #2;
        rst_n = 1'b1;
        step();
        step();
        check("ar_dropped", 64'(res_valid), 64'd0);
        send(3'b001, 32'd100, 32'd1, 4'd8);
        get_result("ar_after", 32'd99, 4'd8, 1'b0, 1'b0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Command front-end that sits directly upstream of the ALU control decoder and datapath.
- Buffers ALU commands (3-bit op, two operands, tag) arriving on a valid/ready interface in a small FIFO.
- Issues one command at a time by registering op and operands onto the ALU inputs, then captures the combinational ALU result into an output register.
- Presents the captured result downstream with its own valid/ready handshake, plus zero and illegal-op flags.

Parameters:
- WIDTH, 32, operand/result width in bits.
- DEPTH, 2, command FIFO entries; power of 2, at least 2.
- TAGW, 4, width of the command tag carried alongside each command.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all pending work.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command may be accepted.
- cmd_op  in  3  ALU opcode: 000 ADD, 001 SUB, 010 SRA, 011 SRL, 100 SLL, 101 AND, 110 OR, 111 illegal.
- cmd_a  in  WIDTH  operand A.
- cmd_b  in  WIDTH  operand B.
- cmd_tag  in  TAGW  opaque ID, returned with the result.
- alu_op  out  3  registered opcode to the ALU control decoder.
- alu_a  out  WIDTH  registered operand A to the ALU.
- alu_b  out  WIDTH  registered operand B to the ALU.
- alu_result  in  WIDTH  combinational ALU output for alu_op/alu_a/alu_b.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  WIDTH  captured result.
- res_tag  out  TAGW  tag of the command that produced res_data.
- res_zero  out  1  res_data == 0.
- res_illegal  out  1  command opcode was 111.
- fifo_count  out  clog2(DEPTH)+1  FIFO occupancy.
- busy  out  1  state != IDLE or fifo_count != 0.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO empty, state IDLE.
  - alu_op/alu_a/alu_b = 0.
  - res_valid/res_data/res_tag/res_zero/res_illegal = 0.
  - fifo_count = 0, busy = 0, cmd_ready = 1 once rst_n is high.
- Push and pop:
  - cmd_ready = (fifo_count != DEPTH). It is purely registered-state derived, with no combinational path from cmd_valid or res_ready.
  - Push on clk edge when cmd_valid & cmd_ready.
  - Pop is internal, in IDLE→EXEC or DONE→EXEC transitions.
  - Same-edge push and pop is allowed when not full; count is unchanged.
  - When full, push is blocked; pop on that edge makes cmd_ready high the next cycle.
- FSM states: IDLE, EXEC, DONE.
  - IDLE: if fifo_count != 0, pop head into alu_op/alu_a/alu_b plus an internal tag register, then go to EXEC. Otherwise hold.
  - EXEC: exactly one cycle. At the edge ending EXEC, capture the result and go to DONE:
    - res_data = alu_result, res_tag = tag reg, res_illegal = (alu_op == 111), res_zero = (captured value == 0).
    - For an illegal op, res_data is forced to 0 (so res_zero = 1).
    - res_valid goes to 1.
  - DONE: hold res_* stable while res_valid & !res_ready. On the res_valid & res_ready edge:
    - if the FIFO is non-empty (including a command pushed the same edge? no, only entries present before the edge), pop directly into EXEC; res_valid goes to 0;
    - else go to IDLE with res_valid = 0.
- Timing:
  - Latency: command accepted at edge k into an idle, empty block → EXEC loaded at edge k+1 → res_valid high after edge k+2.
  - Throughput: one result per 2 cycles with res_ready held high.
- alu_op/alu_a/alu_b change only at the pop edge and hold otherwise, so the ALU inputs are stable for the whole EXEC cycle.
- Capacity: with res_ready low there are at most DEPTH queued commands plus one result in DONE; cmd_ready stays low beyond that.
- flush (synchronous, priority over all other actions except reset):
  - empties the FIFO and returns to IDLE;
  - res_valid = 0;
  - alu_* and res_data are held;
  - a push on the flush edge is discarded.
- FIFO pointers wrap modulo DEPTH; count is kept separately so full and empty are unambiguous.
- Reset mid-operation drops all queued and in-flight commands without producing any result.

Test Plan:
- Reset: hold rst_n=0 with cmd_valid=1 → cmd_ready, res_valid, fifo_count all 0. Release → cmd_ready=1, busy=0.
- ADD: op=000, a=5, b=3, tag=7 at edge k, res_ready=1 → alu_op=000 after edge k+1; res_valid=1 after edge k+2 with res_data=8, res_tag=7, res_zero=0, res_illegal=0.
- SUB wrap: op=001, a=3, b=5 → res_data=0xFFFFFFFE, res_zero=0. Then SUB a=9, b=9 → res_data=0, res_zero=1.
- Backpressure: res_ready=0, push 4 back-to-back commands → first three accepted (one in DONE, fifo_count=2), cmd_ready=0 on the 4th. Raise res_ready → results emerge in push order with matching tags every 2 cycles.
- Illegal and flush:
  - op=111, a=1, b=1 → res_illegal=1, res_data=0, res_zero=1.
  - Then queue 2 commands and assert flush for 1 cycle → fifo_count=0, res_valid=0, IDLE, no further results.
- Async reset in EXEC: drop rst_n mid-cycle → outputs clear immediately without waiting for clk. After release, the next command completes normally.
